cfo_autocorr: RTL and testbench

//  Delay-and-correlate front end of the CFO estimator, directly upstream of the arctan stage.

---
 rtl/cfo_autocorr.sv | 161 ++++++++++++++++
 tb/tb_cfo_autocorr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cfo_autocorr.sv
// cfo_autocorr: delay-and-correlate front end of the CFO estimator.
//   Computes R = sum over L samples of x[n]*conj(x[n-D]) on a complex
//   preamble. The result is emitted as one packed {im,re} word with a
//   single-cycle valid, ready for the arctan stage.
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   start        one-cycle pulse, begins an estimate (honoured in IDLE only)
//   din          sample {im, re}, each DW bits, two's complement
//   din_tvalid   din valid this cycle; low = stall
//   dout         scaled R {im, re}, each OW bits, signed
//   dout_tvalid  one-cycle pulse when dout carries a new result
//   busy         high in every state except IDLE
module cfo_autocorr #(
  parameter int DW = 12,
  parameter int D  = 16,
  parameter int L  = 64,
  parameter int OW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] din,
  input  logic            din_tvalid,
  output logic [2*OW-1:0] dout,
  output logic            dout_tvalid,
  output logic            busy
);

  localparam int PW   = 2 * DW + 1;
  localparam int AW   = PW + $clog2(L);
  localparam int MAXC = (D > L) ? D : L;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic [2:0] {IDLE, FILL, ACC, DRAIN, OUT} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic signed [DW-1:0]   dly_re [D];
  logic signed [DW-1:0]   dly_im [D];
  logic signed [PW-1:0]   prod_re, prod_im;
  logic                   prod_valid;
  logic signed [AW-1:0]   acc_re, acc_im;
  logic signed [OW-1:0]   out_re, out_im;

  // Current sample p and lag-D tail q, sign-extended to product width so the
  // multiplies are carried out at full precision.
  logic signed [DW-1:0] p_re, p_im;
  logic signed [PW-1:0] pr, pi, qr, qi;
  logic signed [PW-1:0] mul_re, mul_im;

  assign p_re   = $signed(din[DW-1:0]);
  assign p_im   = $signed(din[2*DW-1:DW]);
  assign pr     = PW'(p_re);
  assign pi     = PW'(p_im);
  assign qr     = PW'(dly_re[D-1]);
  assign qi     = PW'(dly_im[D-1]);
  assign mul_re = pr * qr + pi * qi;
  assign mul_im = pi * qr - pr * qi;

  logic accept, start_ok, last_fill, last_acc;

  assign accept    = din_tvalid && (state == FILL || state == ACC);
  assign start_ok  = (state == IDLE) && start;
  assign last_fill = accept && (state == FILL) && (cnt == CW'(D - 1));
  assign last_acc  = accept && (state == ACC)  && (cnt == CW'(L - 1));
  assign busy      = (state != IDLE);

  // Scaling: keep the top OW bits (arithmetic shift by AW-OW, truncating),
  // or sign-extend when the accumulator is no wider than the output.
  generate
    if (AW > OW) begin : g_shift
      assign out_re = acc_re[AW-1 -: OW];
      assign out_im = acc_im[AW-1 -: OW];
    end else begin : g_extend
      assign out_re = OW'(acc_re);
      assign out_im = OW'(acc_im);
    end
  endgenerate

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = FILL;
      FILL:    if (last_fill) state_nxt = ACC;
      ACC:     if (last_acc)  state_nxt = DRAIN;
      DRAIN:                  state_nxt = OUT;
      OUT:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok || last_fill || last_acc) cnt <= '0;
      else if (accept)                       cnt <= cnt + 1'b1;
    end
  end

  // NOTE: the delay line is explicitly cleared on reset; it is small and a
  // clean tail keeps post-reset behaviour fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        dly_re[i] <= '0;
        dly_im[i] <= '0;
      end
    end else if (accept) begin
      dly_re[0] <= p_re;
      dly_im[0] <= p_im;
      for (int i = 1; i < D; i++) begin
        dly_re[i] <= dly_re[i-1];
        dly_im[i] <= dly_im[i-1];
      end
    end
  end

  // Product register followed by a valid-qualified accumulate: a stall leaves
  // prod_valid low and the accumulators untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_re    <= '0;
      prod_im    <= '0;
      prod_valid <= 1'b0;
      acc_re     <= '0;
      acc_im     <= '0;
    end else begin
      prod_valid <= accept && (state == ACC);
      if (accept && state == ACC) begin
        prod_re <= mul_re;
        prod_im <= mul_im;
      end
      if (start_ok) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (prod_valid) begin
        acc_re <= acc_re + AW'(prod_re);
        acc_im <= acc_im + AW'(prod_im);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      dout_tvalid <= 1'b0;
    end else begin
      dout_tvalid <= (state == OUT);
      if (state == OUT) dout <= {out_im, out_re};
    end
  end

endmodule

// File: tb/tb_cfo_autocorr.sv
// tb_cfo_autocorr: directed bench for cfo_autocorr at default parameters
// (DW=12, D=16, L=64, OW=24; accumulator 31 bits, output shift 7).
module tb_cfo_autocorr;

  localparam int DW = 12;
  localparam int D  = 16;
  localparam int L  = 64;
  localparam int OW = 24;
  localparam int NS = D + L;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2*DW-1:0] din;
  logic            din_tvalid;
  logic [2*OW-1:0] dout;
  logic            dout_tvalid;
  logic            busy;

  int tests = 0;
  int fails = 0;

  cfo_autocorr #(.DW(DW), .D(D), .L(L), .OW(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .din         (din),
    .din_tvalid  (din_tvalid),
    .dout        (dout),
    .dout_tvalid (dout_tvalid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    tests++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int dout_re();
    return int'($signed(dout[OW-1:0]));
  endfunction

  function automatic int dout_im();
    return int'($signed(dout[2*OW-1:OW]));
  endfunction

  // Sample generators. kind 0: DC re=1000; 1: tone +pi/32; 2: tone -pi/32;
  // 3: full scale re=im=-2048.
  function automatic int gen_re(input int kind, input int n);
    real w;
    w = 3.14159265358979 / 32.0;
    case (kind)
      0:       return 1000;
      1, 2:    return int'(1000.0 * $cos(w * n));
      default: return -2048;
    endcase
  endfunction

  function automatic int gen_im(input int kind, input int n);
    real w;
    w = 3.14159265358979 / 32.0;
    case (kind)
      0:       return 0;
      1:       return int'(1000.0 * $sin(w * n));
      2:       return -int'(1000.0 * $sin(w * n));
      default: return -2048;
    endcase
  endfunction

  // One clock cycle of input; inputs change 1 time unit after the rising edge.
  task automatic drive(input int re, input int im, input bit vld);
    din        = {DW'(im), DW'(re)};
    din_tvalid = vld;
    @(posedge clk);
    #1;
    din_tvalid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Feeds samples first..first+n-1 of a pattern; with stall set, each valid
  // sample is preceded by an idle cycle carrying junk data.
  task automatic feed(input int kind, input int first, input int n, input bit stall);
    for (int i = first; i < first + n; i++) begin
      if (stall) drive(777, -555, 1'b0);
      drive(gen_re(kind, i), gen_im(kind, i), 1'b1);
    end
  endtask

  // Called just after edge k (last ACC sample accepted). Checks k+1 quiet and
  // the pulse with the result at k+2; returns still inside the pulse cycle.
  task automatic expect_result(input string tag, input int exp_re, input int exp_im, input int tol);
    @(posedge clk);
    #1;
    check({tag, "_tvalid_k1"}, int'(dout_tvalid), 0);
    @(posedge clk);
    #1;
    check({tag, "_tvalid_k2"}, int'(dout_tvalid), 1);
    check({tag, "_busy_k2"}, int'(busy), 0);
    check_near({tag, "_re"}, dout_re(), exp_re, tol);
    check_near({tag, "_im"}, dout_im(), exp_im, tol);
  endtask

  task automatic expect_fall(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_tvalid_k3"}, int'(dout_tvalid), 0);
  endtask

  initial begin
    bit seen;
    rst_n      = 1'b0;
    start      = 1'b0;
    din        = '0;
    din_tvalid = 1'b0;
    #23;
    check("rst_dout",   int'(dout), 0);
    check("rst_tvalid", int'(dout_tvalid), 0);
    check("rst_busy",   int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Samples offered in IDLE are discarded.
    drive(1234, -999, 1'b1);
    drive(-77, 42, 1'b1);
    check("idle_busy", int'(busy), 0);

    // 1: DC.
    do_start();
    check("t1_busy", int'(busy), 1);
    feed(0, 0, NS, 1'b0);
    expect_result("t1_dc", 500000, 0, 0);
    expect_fall("t1_dc");

    // 2: positive tone.
    do_start();
    feed(1, 0, NS, 1'b0);
    expect_result("t2_tone_pos", 0, 500000, 2000);
    expect_fall("t2_tone_pos");

    // 3: negative tone; result pulse cycle then carries a back-to-back start.
    do_start();
    feed(2, 0, NS, 1'b0);
    expect_result("t3_tone_neg", 0, -500000, 2000);

    // 4: full scale, started on the dout_tvalid cycle.
    do_start();
    check("t4_b2b_tvalid_fall", int'(dout_tvalid), 0);
    check("t4_b2b_busy", int'(busy), 1);
    feed(3, 0, NS, 1'b0);
    expect_result("t4_full", 4194304, 0, 0);
    expect_fall("t4_full");

    // 5: DC with din_tvalid toggling every cycle.
    do_start();
    feed(0, 0, NS, 1'b1);
    expect_result("t5_stall", 500000, 0, 0);
    expect_fall("t5_stall");

    // 6a: start pulse while busy is ignored.
    do_start();
    feed(0, 0, 30, 1'b0);
    do_start();
    check("t6a_busy", int'(busy), 1);
    feed(0, 30, NS - 30, 1'b0);
    expect_result("t6a_start_ignored", 500000, 0, 0);
    expect_fall("t6a_start_ignored");

    // 6b: reset mid-ACC aborts with outputs cleared and no later pulse.
    do_start();
    feed(3, 0, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6b_rst_dout",   int'(dout), 0);
    check("t6b_rst_tvalid", int'(dout_tvalid), 0);
    check("t6b_rst_busy",   int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      drive(1000, 0, 1'b1);
      if (dout_tvalid) seen = 1'b1;
    end
    check("t6b_no_pulse", int'(seen), 0);
    check("t6b_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
